// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag helpers for the sequential ALU.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_NAND = 5'd7;
  localparam logic [4:0] ALU_NOR  = 5'd8;
  localparam logic [4:0] ALU_XNOR = 5'd9;
  localparam logic [4:0] ALU_NOT  = 5'd10;
  localparam logic [4:0] ALU_COMP = 5'd11;
  localparam logic [4:0] ALU_SRA  = 5'd12;
  localparam logic [4:0] ALU_SUBO = 5'd13;
  localparam logic [4:0] ALU_SIG  = 5'd14;
  localparam logic [4:0] ALU_SOME = 5'd15;
  localparam logic [4:0] ALU_MUL  = 5'd16;
  localparam logic [4:0] ALU_DIV  = 5'd17;
  localparam logic [4:0] ALU_REM  = 5'd18;
  localparam logic [4:0] ALU_SLT  = 5'd19;

  localparam int unsigned ALU_ILLEGAL = 20;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] MD_MUL = 2'd0;
  localparam logic [1:0] MD_DIV = 2'd1;
  localparam logic [1:0] MD_REM = 2'd2;

  // Signed overflow of s = a + b, expressed on the sign bits only.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done_pulse,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi,
  output logic                  dbz
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic                  mul_q, mul_d;
  logic                  dbz_q, dbz_d;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH+1:0] trial;

  always_comb begin
    cnt_d  = cnt_q;
    opnd_d = opnd_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    mul_d  = mul_q;
    dbz_d  = dbz_q;
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    trial  = {1'b0, hi_q, lo_q[DATA_WIDTH-1]} - {2'b00, opnd_q};
    if (start) begin
      cnt_d  = CW'(DATA_WIDTH);
      mul_d  = (op == MD_MUL);
      dbz_d  = (op != MD_MUL) && (b == '0);
      hi_d   = '0;
      // Multiply keeps the multiplier in lo; divide keeps the dividend there.
      opnd_d = (op == MD_MUL) ? a : b;
      lo_d   = (op == MD_MUL) ? b : a;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (mul_q) begin
        hi_d = sum[DATA_WIDTH:1];
        lo_d = {sum[0], lo_q[DATA_WIDTH-1:1]};
      end else if (!trial[DATA_WIDTH+1]) begin
        hi_d = trial[DATA_WIDTH-1:0];
        lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[DATA_WIDTH-2:0], lo_q[DATA_WIDTH-1]};
        lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      opnd_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      mul_q  <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      opnd_q <= opnd_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      mul_q  <= mul_d;
      dbz_q  <= dbz_d;
    end
  end

  // lo/hi present the final step's result during done_pulse so it lands on that edge.
  assign busy       = (cnt_q != '0);
  assign done_pulse = (cnt_q == CW'(1));
  assign lo         = lo_d;
  assign hi         = hi_d;
  assign dbz        = dbz_q;

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with valid/ready handshakes and an iterative mul/div unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OP_SIZE    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] rega,
  input  logic [DATA_WIDTH-1:0] regb,
  input  logic [OP_SIZE-1:0]    control,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu,
  output logic [DATA_WIDTH-1:0] out_hi,
  output logic                  cout,
  output logic                  zero,
  output logic                  equal,
  output logic                  ovf,
  output logic                  neg,
  output logic                  dbz
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam int unsigned M   = DATA_WIDTH - 1;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] out_alu_q, out_alu_d, out_hi_q, out_hi_d;
  logic                  cout_q, cout_d, zero_q, zero_d, equal_q, equal_d;
  logic                  ovf_q, ovf_d, neg_q, neg_d, dbz_q, dbz_d;
  logic                  eq_q, eq_d, rem_sel_q, rem_sel_d;

  logic [4:0]            opc;
  logic                  legal, is_md, md_start, md_busy, md_done, md_dbz;
  logic [1:0]            md_op;
  logic [DATA_WIDTH-1:0] md_lo, md_hi, md_res, res;
  logic [DATA_WIDTH:0]   sum;
  logic                  cout_c, ovf_c;
  logic [SHW-1:0]        sh;

  assign opc    = control[4:0];
  assign legal  = (control < OP_SIZE'(ALU_ILLEGAL));
  assign is_md  = legal && ((opc == ALU_MUL) || (opc == ALU_DIV) || (opc == ALU_REM));
  assign md_op  = (opc == ALU_MUL) ? MD_MUL : ((opc == ALU_DIV) ? MD_DIV : MD_REM);
  assign sh     = regb[SHW-1:0];
  assign md_res = rem_sel_q ? md_hi : md_lo;

  always_comb begin
    res    = '0;
    sum    = '0;
    cout_c = 1'b0;
    ovf_c  = 1'b0;
    if (legal) begin
      case (opc)
        ALU_ADD: begin
          sum    = {1'b0, rega} + {1'b0, regb};
          res    = sum[M:0];
          cout_c = sum[DATA_WIDTH];
          ovf_c  = add_ovf(rega[M], regb[M], sum[M]);
        end
        ALU_SUB: begin
          sum    = {1'b0, rega} - {1'b0, regb};
          res    = sum[M:0];
          cout_c = sum[DATA_WIDTH];
          ovf_c  = add_ovf(rega[M], ~regb[M], sum[M]);
        end
        ALU_AND:  res = rega & regb;
        ALU_OR:   res = rega | regb;
        ALU_XOR:  res = rega ^ regb;
        ALU_SLL:  res = rega << sh;
        ALU_SRL:  res = rega >> sh;
        ALU_NAND: res = ~(rega & regb);
        ALU_NOR:  res = ~(rega | regb);
        ALU_XNOR: res = ~(rega ^ regb);
        ALU_NOT:  res = ~rega;
        ALU_SRA:  res = $signed(rega) >>> sh;
        ALU_SUBO: begin
          sum    = {1'b0, rega} - {{DATA_WIDTH{1'b0}}, 1'b1};
          res    = sum[M:0];
          cout_c = sum[DATA_WIDTH];
          ovf_c  = add_ovf(rega[M], 1'b1, sum[M]);
        end
        ALU_SIG: begin
          sum   = '0 - {1'b0, rega};
          res   = sum[M:0];
          ovf_c = add_ovf(1'b0, ~rega[M], sum[M]);
        end
        ALU_SOME: begin
          sum    = {1'b0, rega} + {1'b0, ~regb};
          res    = sum[M:0];
          cout_c = sum[DATA_WIDTH];
          ovf_c  = add_ovf(rega[M], ~regb[M], sum[M]);
        end
        ALU_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, ($signed(rega) < $signed(regb))};
        default:  res = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    out_alu_d = out_alu_q;
    out_hi_d  = out_hi_q;
    cout_d    = cout_q;
    zero_d    = zero_q;
    equal_d   = equal_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    dbz_d     = dbz_q;
    eq_d      = eq_q;
    rem_sel_d = rem_sel_q;
    md_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          eq_d      = (rega == regb);
          rem_sel_d = (opc == ALU_REM);
          if (is_md) begin
            md_start = !md_busy;
            state_d  = CALC;
          end else begin
            // Illegal opcodes clear every result output, flags included.
            out_alu_d = res;
            out_hi_d  = '0;
            cout_d    = cout_c;
            ovf_d     = ovf_c;
            zero_d    = legal && (res == '0);
            neg_d     = res[M];
            equal_d   = legal && (rega == regb);
            dbz_d     = 1'b0;
            state_d   = DONE;
          end
        end
      end
      CALC: begin
        if (md_done) begin
          out_alu_d = md_res;
          out_hi_d  = md_hi;
          cout_d    = 1'b0;
          ovf_d     = 1'b0;
          zero_d    = (md_res == '0);
          neg_d     = md_res[M];
          equal_d   = eq_q;
          dbz_d     = md_dbz;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      out_alu_q <= '0;
      out_hi_q  <= '0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
      equal_q   <= 1'b0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      dbz_q     <= 1'b0;
      eq_q      <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_alu_q <= out_alu_d;
      out_hi_q  <= out_hi_d;
      cout_q    <= cout_d;
      zero_q    <= zero_d;
      equal_q   <= equal_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
      dbz_q     <= dbz_d;
      eq_q      <= eq_d;
      rem_sel_q <= rem_sel_d;
    end
  end

  alu_muldiv_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .start      (md_start),
    .op         (md_op),
    .a          (rega),
    .b          (regb),
    .busy       (md_busy),
    .done_pulse (md_done),
    .lo         (md_lo),
    .hi         (md_hi),
    .dbz        (md_dbz)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_alu   = out_alu_q;
  assign out_hi    = out_hi_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign equal     = equal_q;
  assign ovf       = ovf_q;
  assign neg       = neg_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] rega, regb, out_alu, out_hi;
  logic [4:0]  control;
  logic        cout, zero, equal, ovf, neg, dbz;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] hi;
    logic        cout;
    logic        zero;
    logic        equal;
    logic        ovf;
    logic        neg;
    logic        dbz;
  } res_t;

  alu_seq #(
    .DATA_WIDTH (16),
    .OP_SIZE    (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rega      (rega),
    .regb      (regb),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_alu   (out_alu),
    .out_hi    (out_hi),
    .cout      (cout),
    .zero      (zero),
    .equal     (equal),
    .ovf       (ovf),
    .neg       (neg),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  function automatic bit out_of_range(input int v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic res_t model(input int op, input logic [15:0] a, input logic [15:0] b);
    res_t   m;
    int     ua, ub, sa, sb, sh, s;
    longint p;
    m  = '0;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = ub % 16;
    s  = 0;
    if (op >= 20) return m;
    case (op)
      0:  begin s = ua + ub; m.alu = s[15:0]; m.cout = (s > 65535); m.ovf = out_of_range(sa + sb); end
      1:  begin s = ua - ub; m.alu = s[15:0]; m.cout = (ua < ub); m.ovf = out_of_range(sa - sb); end
      2:  m.alu = a & b;
      3:  m.alu = a | b;
      4:  m.alu = a ^ b;
      5:  m.alu = a << sh;
      6:  m.alu = a >> sh;
      7:  m.alu = ~(a & b);
      8:  m.alu = ~(a | b);
      9:  m.alu = ~(a ^ b);
      10: m.alu = ~a;
      11: m.alu = 16'h0000;
      12: m.alu = 16'(sa >>> sh);
      13: begin s = ua - 1; m.alu = s[15:0]; m.cout = (ua == 0); m.ovf = out_of_range(sa - 1); end
      14: begin s = -ua; m.alu = s[15:0]; m.ovf = out_of_range(-sa); end
      15: begin
        s      = ua + (65535 - ub);
        m.alu  = s[15:0];
        m.cout = (s > 65535);
        m.ovf  = out_of_range(sa + (-sb - 1));
      end
      16: begin p = longint'(ua) * longint'(ub); m.alu = p[15:0]; m.hi = p[31:16]; end
      17, 18: begin
        if (ub == 0) begin
          m.alu = 16'hFFFF;
          m.hi  = a;
          m.dbz = 1'b1;
        end else begin
          s     = ua / ub;
          m.alu = s[15:0];
          s     = ua % ub;
          m.hi  = s[15:0];
        end
        if (op == 18) m.alu = m.hi;
      end
      default: m.alu = (sa < sb) ? 16'h0001 : 16'h0000;
    endcase
    m.zero  = (m.alu == 16'h0000);
    m.equal = (a == b);
    m.neg   = m.alu[15];
    return m;
  endfunction

  function automatic res_t obs();
    res_t r;
    r.alu   = out_alu;
    r.hi    = out_hi;
    r.cout  = cout;
    r.zero  = zero;
    r.equal = equal;
    r.ovf   = ovf;
    r.neg   = neg;
    r.dbz   = dbz;
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("alu=%h hi=%h c=%b z=%b e=%b v=%b n=%b d=%b",
                     r.alu, r.hi, r.cout, r.zero, r.equal, r.ovf, r.neg, r.dbz);
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Issue one request, scramble the inputs after the accept edge, wait for the result,
  // then optionally stall out_ready for hold cycles before consuming it.
  task automatic do_op(input int op, input logic [15:0] a, input logic [15:0] b, input int hold,
                       output res_t got, output int lat, output bit to);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b1;
    rega      = a;
    regb      = b;
    control   = 5'(op);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rega     = 16'($urandom);
    regb     = 16'($urandom);
    control  = 5'($urandom_range(0, 31));
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    to  = !out_valid;
    got = obs();
    repeat (hold) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
    checks++;
    if (obs() !== res_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %s, expected all zero", fmt(obs()));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add_carry();
    res_t got, exp;
    int   lat;
    bit   to;
    exp = model(0, 16'hFFFF, 16'h0001);
    do_op(0, 16'hFFFF, 16'h0001, 0, got, lat, to);
    checks++;
    if (to || got !== exp || got.alu !== 16'h0000 || got.cout !== 1'b1 || got.zero !== 1'b1) begin
      errors++;
      $display("FAIL add_carry: got %s, expected %s", fmt(got), fmt(exp));
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL add_latency: got %0d cycles, expected 1", lat);
    end
  endtask

  task automatic test_add_ovf();
    res_t got, exp;
    int   lat;
    bit   to;
    exp = model(0, 16'h7FFF, 16'h0001);
    do_op(0, 16'h7FFF, 16'h0001, 2, got, lat, to);
    checks++;
    if (to || got !== exp || got.alu !== 16'h8000 || got.ovf !== 1'b1 || got.neg !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf: got %s, expected %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_mul();
    res_t got;
    int   lat;
    bit   to;
    do_op(16, 16'h1234, 16'h5678, 0, got, lat, to);
    checks++;
    if (to || {got.hi, got.alu} !== 32'h0626_0060) begin
      errors++;
      $display("FAIL mul_product: got %h_%h, expected 0626_0060", got.hi, got.alu);
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL mul_latency: got %0d cycles, expected 17", lat);
    end
  endtask

  task automatic test_div();
    res_t got;
    int   lat;
    bit   to;
    do_op(17, 16'd100, 16'd7, 1, got, lat, to);
    checks++;
    if (to || got.alu !== 16'd14 || got.hi !== 16'd2 || got.dbz !== 1'b0) begin
      errors++;
      $display("FAIL div: got %s, expected alu=000e hi=0002 d=0", fmt(got));
    end
    do_op(17, 16'd100, 16'd0, 0, got, lat, to);
    checks++;
    if (to || got.alu !== 16'hFFFF || got.hi !== 16'd100 || got.dbz !== 1'b1) begin
      errors++;
      $display("FAIL div_by_zero: got %s, expected alu=ffff hi=0064 d=1", fmt(got));
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_valid  = 1'b1;
    rega      = 16'h8000;
    regb      = 16'h0004;
    control   = 5'd12;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_alu !== 16'hF800 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b alu=%h in_ready=%b, expected 1/f800/0",
                 i, out_valid, out_alu, in_ready);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_alu !== 16'hF800) begin
      errors++;
      $display("FAIL backpressure_reaccept: valid=%b alu=%h, expected 1/f800", out_valid, out_alu);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    res_t exp;
    int   highs;
    bit   prev;
    logic [15:0] a, b;
    a     = 16'($urandom);
    b     = 16'($urandom);
    exp   = model(0, a, b);
    highs = 0;
    prev  = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    rega      = a;
    regb      = b;
    control   = 5'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        highs++;
        checks++;
        if (prev || obs() !== exp) begin
          errors++;
          $display("FAIL back_to_back[%0d]: prev=%b got %s, expected %s", i, prev, fmt(obs()),
                   fmt(exp));
        end
      end
      prev = out_valid;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (highs !== 5) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d pulses in 10 cycles, expected 5", highs);
    end
  endtask

  task automatic test_reset_mid_calc();
    res_t got;
    int   lat, pulses;
    bit   to;
    @(negedge clk);
    in_valid = 1'b1;
    rega     = 16'($urandom);
    regb     = 16'($urandom);
    control  = 5'd16;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL calc_busy: in_ready=%b out_valid=%b, expected 0/0", in_ready, out_valid);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_discard: got %0d valid cycles after release, expected 0", pulses);
    end
    // Reset while a single-cycle result waits in DONE.
    @(negedge clk);
    in_valid = 1'b1;
    rega     = 16'h0003;
    regb     = 16'h0004;
    control  = 5'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs() !== res_t'(0)) begin
      errors++;
      $display("FAIL reset_mid_done: valid=%b in_ready=%b got %s, expected 0/1/zero", out_valid,
               in_ready, fmt(obs()));
    end
    @(negedge clk);
    reset = 1'b0;
    do_op(0, 16'd1, 16'd1, 0, got, lat, to);
    checks++;
    if (to || got.alu !== 16'd2 || lat !== 1) begin
      errors++;
      $display("FAIL add_after_reset: alu=%h lat=%0d timeout=%b, expected 0002/1/0", got.alu, lat,
               to);
    end
  endtask

  task automatic test_random();
    res_t got, exp;
    int   op, lat, exp_lat;
    bit   to;
    logic [15:0] a, b;
    for (int i = 0; i < 300; i++) begin
      op      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 31))
                                            : int'($urandom_range(0, 19));
      a       = pick_operand();
      b       = ($urandom_range(0, 1) == 0) ? a : pick_operand();
      exp     = model(op, a, b);
      exp_lat = (op >= 16 && op <= 18) ? 17 : 1;
      do_op(op, a, b, int'($urandom_range(0, 2)), got, lat, to);
      checks++;
      if (op >= 20) begin
        if (to || {got.alu, got.hi, got.cout, got.ovf, got.neg, got.dbz} !== '0) begin
          errors++;
          $display("FAIL random_illegal op=%0d: got %s, expected zero results", op, fmt(got));
        end
      end else if (to || got !== exp) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h: got %s, expected %s", op, a, b, fmt(got),
                 fmt(exp));
      end
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL random_latency op=%0d: got %0d, expected %0d", op, lat, exp_lat);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rega      = '0;
    regb      = '0;
    control   = '0;
    test_reset();
    test_add_carry();
    test_add_ovf();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
